// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer: steps a 3-bit decoder select through enabled channels with dwell and blanking.
// Optional `SCAN_PASS_COUNT_EN adds a saturating pass_count output.
module scan_select_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap
`ifdef SCAN_PASS_COUNT_EN
  ,
  output logic [7:0]         pass_count
`endif
);
  typedef enum logic [1:0] {IDLE, SEEK, DWELL, DONE} state_t;
  state_t state;
  logic [7:0] sh_mask;
  logic [DWELL_W-1:0] sh_dwell, cnt, d_m1;
  logic sh_mode, stop_l, stop_eff;
  logic [3:0] ptr;
  logic [2:0] found;
  logic [7:0] above;
  always_comb begin
    found = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (sh_mask[i] && 4'(i) >= ptr) found = 3'(i);
  end
  assign above = sh_mask & (8'hFE << sel);
  assign d_m1 = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;
  assign stop_eff = stop_l | stop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= 3'd0;
      sel_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      wrap <= 1'b0;
      sh_mask <= 8'd0;
      sh_dwell <= '0;
      sh_mode <= 1'b0;
      cnt <= '0;
      ptr <= 4'd0;
      stop_l <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh_mask <= ch_mask;
          sh_dwell <= dwell;
          sh_mode <= mode;
          ptr <= 4'd0;
          state <= (ch_mask == 8'd0) ? DONE : SEEK;
          done <= (ch_mask == 8'd0);
          busy <= (ch_mask != 8'd0);
        end
        SEEK: begin
          sel <= found;
          sel_valid <= 1'b1;
          cnt <= d_m1;
          state <= DWELL;
          if (stop) stop_l <= 1'b1;
        end
        DWELL: begin
          if (stop) stop_l <= 1'b1;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            sel_valid <= 1'b0;
            if (stop_eff || (~|above && (!sh_mode || ch_mask == 8'd0))) begin
              if (!stop_eff && sh_mode) begin
                sh_mask <= ch_mask;
                sh_dwell <= dwell;
                sh_mode <= mode;
              end
              state <= DONE;
              done <= 1'b1;
              busy <= 1'b0;
            end else if (|above) begin
              ptr <= {1'b0, sel} + 4'd1;
              state <= SEEK;
            end else begin
              // continuous wrap: new pass picks up the live configuration
              sh_mask <= ch_mask;
              sh_dwell <= dwell;
              sh_mode <= mode;
              ptr <= 4'd0;
              wrap <= 1'b1;
              state <= SEEK;
            end
          end
        end
        default: begin
          state <= IDLE;
          stop_l <= 1'b0;
        end
      endcase
    end
  end
`ifdef SCAN_PASS_COUNT_EN
  logic end_pass;
  assign end_pass = (state == DWELL) && (cnt == '0) && !stop_eff && ~|above;
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) pass_count <= 8'd0;
    else if (end_pass && pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
  end
`endif
endmodule
